pwm_phase_timer: RTL
====================

# pwm_phase_timer

Phase timer at the far end of the PWM frequency-selector handshake. It consumes the selector's current phase length (`period_in`, in clk cycles), counts it out, and drives `pwm_out`. At every phase boundary it returns a one-cycle `done` pulse so the selector swaps between its high and low lengths. The block sits between the selector and the output pin/driver and owns all PWM timing.

## Interface
- `CNT_W`, default 32: width of `period_in` and the internal counter.
- `PCNT_W`, default 16: width of `period_cnt`.
- `MIN_PHASE`, fixed 3 (package constant, not overridable): minimum phase length in cycles.

- `clk`  input  1: clock.
- `reset`  input  1: reset, synchronous, active-high.
- `enable`  input  1: run request; sampled only at the points defined under Operation.
- `period_in`  input  CNT_W: length of the current phase in clk cycles, from the selector.
- `done`  output  1: one-cycle pulse, registered, high in the cycle after each `pwm_out` toggle.
- `pwm_out`  output  1: PWM level; 0 = LOW phase, 1 = HIGH phase.
- `busy`  output  1: high whenever state ≠ IDLE.
- `period_cnt`  output  PCNT_W: number of completed HIGH→LOW periods, wraps modulo 2^PCNT_W.

## Operation
- States: IDLE, WAIT, LOAD, COUNT. Internal registers: `cnt` (CNT_W), `len` (CNT_W).
- Reset, and reset mid-operation: state IDLE; `cnt` 0; `len` 0; `done` 0; `pwm_out` 0; `period_cnt` 0. This matches the selector's reset state, LOW, which presents the low length.
- IDLE: `pwm_out` held at 0. If `enable` is 1, go to LOAD with `cnt` ← 2. No `done` is issued, because the selector is already LOW.
- WAIT: always lasts exactly one cycle, the cycle in which `done` is high. `cnt` ← 2, go to LOAD. During this cycle the selector samples `done` and updates its output.
- LOAD: sample `len` ← max(`period_in`, MIN_PHASE), `cnt` ← 3, go to COUNT. This is the first cycle in which the selector's new length is valid.
- COUNT:
  - If `cnt` == `len`, this is a phase end:
    - If `pwm_out` is 1, or `pwm_out` is 0 and `enable` is 1: toggle `pwm_out`, set `done` ← 1, `cnt` ← 1, go to WAIT.
    - If `pwm_out` is 1 at this toggle (HIGH→LOW), also increment `period_cnt`.
    - If `pwm_out` is 0 and `enable` is 0: go to IDLE with no toggle and no `done`. The selector stays LOW, so the two blocks stay consistent.
  - Otherwise `cnt` ← `cnt` + 1.
- `enable` is ignored outside IDLE and the LOW-phase end. Dropping `enable` in the middle of a phase always finishes the current HIGH and LOW phases.
- Width rules:
  - `cnt` never exceeds `len`, so there is no overflow.
  - `period_in` = 2^CNT_W − 1 is legal.
  - `period_in` values 0, 1 and 2 are clamped to 3.
- `period_in` is sampled only in LOAD. Changes at any other time have no effect on the current phase.

## Timing
- A steady-state phase with sampled length P lasts exactly max(P,3) cycles, toggle edge to toggle edge: WAIT, then LOAD, then max(P,3)−2 COUNT cycles.
- `done` is high for exactly one cycle, starting at the toggle edge. It is never high in two consecutive cycles.
- Start-up: the first LOW→HIGH toggle occurs max(P_low,3)−1 cycles after the edge at which IDLE samples `enable` = 1.
- `busy` falls on the same edge that enters IDLE. `pwm_out` is 0 at that point.
- Full period is max(Ph,3) + max(Pl,3) cycles. Duty cycle is the HIGH phase length divided by the full period.

## Structure
- Shared package `pwm_pkg` holds:
  - the state enum `pwm_tmr_state_t` (IDLE, WAIT, LOAD, COUNT);
  - `MIN_PHASE` = 3;
  - the level encodings LVL_LOW = 0 and LVL_HIGH = 1, shared with the selector.
- Single module, no sub-module. Control FSM and counter in one clocked process, next-state logic in one combinational process.
- Integration test: the timer's `done` drives the selector's `done`, and the selector's output drives `period_in`.

## Test plan
- Reset, then hold `enable` = 0 for 20 cycles with `period_in` = 10 → `pwm_out` = 0, `done` = 0, `busy` = 0, `period_cnt` = 0 throughout.
- Closed loop with the selector, high = 4, low = 6, `enable` held at 1 → after start-up, `pwm_out` is high for 4 cycles and low for 6 cycles, repeating. Each `done` is a single cycle aligned to a toggle. `period_cnt` increments once per 10 cycles.
- High = 0, low = 1 → both phases are clamped to 3 cycles, giving a 6-cycle period.
- Drop `enable` in the middle of a HIGH phase (high = 5, low = 5) → the HIGH phase completes, the LOW phase completes, then the block enters IDLE with `pwm_out` = 0, `busy` = 0, and no further `done`. The selector remains LOW.
- Change `period_in` in the middle of a COUNT from 8 to 3 → the current phase still lasts 8 cycles. The new value takes effect only at the next LOAD.
- Assert `reset` in the middle of a HIGH phase, and preload `period_cnt` to 0xFFFF in a separate run → after reset all outputs return to their reset values. In the preload run, the next HIGH→LOW toggle wraps `period_cnt` to 0x0000.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM frequency-selector / phase-timer pair.
package pwm_pkg;

  // Phase-timer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    LOAD  = 2'd2,
    COUNT = 2'd3
  } pwm_tmr_state_t;

  // Shortest phase the timer will produce, in clk cycles. WAIT and LOAD
  // always consume two cycles of every phase, and at least one COUNT cycle
  // is needed to reach the terminal compare.
  localparam int MIN_PHASE = 3;

  // Output level encodings, shared with the selector.
  localparam logic LVL_LOW  = 1'b0;
  localparam logic LVL_HIGH = 1'b1;

endpackage : pwm_pkg

// File: rtl/pwm_phase_timer.sv
// PWM phase timer: counts out the selector's current phase length, drives
// pwm_out, and returns a one-cycle done pulse at every phase boundary so the
// selector swaps between its high and low lengths.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | stopped, pwm_out low; waits for enable
// WAIT  | cycle after a toggle; done is high, selector updates its length
// LOAD  | selector's new length is valid; sample it (clamped) into len
// COUNT | count cnt up to len; phase end on cnt == len
module pwm_phase_timer
  import pwm_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int PCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  period_in,
  output logic              done,
  output logic              pwm_out,
  output logic              busy,
  output logic [PCNT_W-1:0] period_cnt
);

  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_PHASE);

  // cnt values chosen so that cnt reaches len exactly max(P,3) cycles after
  // the toggle: WAIT holds 1, LOAD holds 2, COUNT starts at 3.
  localparam logic [CNT_W-1:0] CNT_WAIT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(3);

  pwm_tmr_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              done_q, done_d;
  logic              pwm_q, pwm_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  period_clamped;

  assign period_clamped = (period_in < MIN_LEN) ? MIN_LEN : period_in;

  // Next-state, counter and output-level decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    pwm_d   = pwm_q;
    pcnt_d  = pcnt_q;

    unique case (state_q)
      IDLE: begin
        pwm_d = LVL_LOW;
        // Selector already presents the low length, so no done here.
        if (enable) begin
          cnt_d   = CNT_LOAD;
          state_d = LOAD;
        end
      end

      WAIT: begin
        cnt_d   = CNT_LOAD;
        state_d = LOAD;
      end

      LOAD: begin
        len_d   = period_clamped;
        cnt_d   = CNT_FIRST;
        state_d = COUNT;
      end

      COUNT: begin
        if (cnt_q == len_q) begin
          // enable only matters at the end of a LOW phase: a HIGH phase
          // always hands over to LOW so the selector ends up LOW too.
          if (pwm_q == LVL_HIGH || enable) begin
            pwm_d   = ~pwm_q;
            done_d  = 1'b1;
            cnt_d   = CNT_WAIT;
            state_d = WAIT;
            if (pwm_q == LVL_HIGH) begin
              pcnt_d = pcnt_q + PCNT_W'(1);
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control FSM, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      pwm_q   <= LVL_LOW;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
      pwm_q   <= pwm_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign done       = done_q;
  assign pwm_out    = pwm_q;
  assign busy       = (state_q != IDLE);
  assign period_cnt = pcnt_q;

endmodule : pwm_phase_timer
